// File: rtl/isp_buf_pkg.sv
// Shared constants and helpers for the ISP SRAM-buffer read engine.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Contents:
//   ADDR_W_DEF / DATA_W_DEF : default SRAM geometry (64 x 8)
//   PTR_W                   : pointer width for the default geometry (wrap bit + address)
//   OBUF_DEPTH / CNT_W      : output skid FIFO depth and its occupancy counter width
//   PTR_W_MAX               : widest pointer ptr_diff() can handle
//   ptr_diff()              : modulo-2**w distance between two pointers
package isp_buf_pkg;

  localparam int ADDR_W_DEF = 6;
  localparam int DATA_W_DEF = 8;
  localparam int PTR_W      = ADDR_W_DEF + 1;

  // Two entries are enough to cover the one-cycle SRAM read latency while
  // keeping full throughput: one byte being presented, one byte landing.
  localparam int OBUF_DEPTH = 2;
  localparam int CNT_W      = $clog2(OBUF_DEPTH + 1);

  localparam int PTR_W_MAX  = 16;

  // Distance wr - rd for pointers that wrap modulo 2**w. Callers zero-extend
  // their pointers to PTR_W_MAX and cast the result back to the width they
  // need, so one function serves every ADDR_W.
  function automatic logic [PTR_W_MAX-1:0] ptr_diff(
    input logic [PTR_W_MAX-1:0] wr,
    input logic [PTR_W_MAX-1:0] rd,
    input int unsigned          w
  );
    logic [PTR_W_MAX-1:0] mask;
    mask = (PTR_W_MAX'(1) << w) - PTR_W_MAX'(1);
    return (wr - rd) & mask;
  endfunction

endpackage

// File: rtl/isp_buf_reader_obuf.sv
// Output skid FIFO (OBUF_DEPTH entries) between the SRAM read port and the byte stream.
// Latency: a pushed byte is visible at head_dat the cycle after the push edge.
// Backpressure: pop only when cnt != 0; push is expected only when there is room (or a pop frees it).
//
// Ports:
//   clk, srst      : clock and synchronous active-high reset (reset wins over flush)
//   flush          : empties the FIFO and drops any push in the same cycle
//   push, push_dat : write one byte into the tail
//   pop            : remove the head byte
//   cnt            : number of bytes held (0..OBUF_DEPTH)
//   head_dat       : oldest byte held; stable while no pop occurs
module isp_buf_reader_obuf
  import isp_buf_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              srst,
  input  logic              flush,
  input  logic              push,
  input  logic [DATA_W-1:0] push_dat,
  input  logic              pop,
  output logic [CNT_W-1:0]  cnt,
  output logic [DATA_W-1:0] head_dat
);

  localparam int IDX_W = (OBUF_DEPTH > 1) ? $clog2(OBUF_DEPTH) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(OBUF_DEPTH - 1);

  logic [DATA_W-1:0] mem_q [OBUF_DEPTH];
  logic [DATA_W-1:0] mem_d [OBUF_DEPTH];
  logic [IDX_W-1:0]  wr_idx_q, wr_idx_d;
  logic [IDX_W-1:0]  rd_idx_q, rd_idx_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic do_push;
  logic do_pop;

  always_comb begin
    mem_d    = mem_q;
    wr_idx_d = wr_idx_q;
    rd_idx_d = rd_idx_q;
    cnt_d    = cnt_q;

    do_pop  = pop & (cnt_q != '0);
    // A push into a full FIFO is only accepted when a pop frees a slot in
    // the same cycle; otherwise it would overwrite the head.
    do_push = push & ~flush & ((cnt_q < CNT_W'(OBUF_DEPTH)) | do_pop);

    if (flush) begin
      // Stored bytes are left in place; with cnt at zero they are unreachable.
      wr_idx_d = '0;
      rd_idx_d = '0;
      cnt_d    = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_idx_q] = push_dat;
        wr_idx_d        = (wr_idx_q == IDX_LAST) ? '0 : wr_idx_q + IDX_W'(1);
      end
      if (do_pop) begin
        rd_idx_d = (rd_idx_q == IDX_LAST) ? '0 : rd_idx_q + IDX_W'(1);
      end
      cnt_d = cnt_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      for (int i = 0; i < OBUF_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_idx_q <= '0;
      rd_idx_q <= '0;
      cnt_q    <= '0;
    end else begin
      for (int i = 0; i < OBUF_DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
      wr_idx_q <= wr_idx_d;
      rd_idx_q <= rd_idx_d;
      cnt_q    <= cnt_d;
    end
  end

  assign cnt      = cnt_q;
  assign head_dat = mem_q[rd_idx_q];

endmodule

// File: rtl/isp_buf_reader.sv
// Read engine for the 2**ADDR_W x DATA_W two-port ISP SRAM buffer; streams bytes out as valid/ready.
// Latency: WR_PTR moves ahead in cycle N -> REN in N -> TVALID in N+2; then 1 byte/cycle gapless.
// Backpressure: TREADY low stops issue once 2 bytes are held or in flight; RD_PTR then lags WR_PTR.
//
// Ports:
//   CLK, SRST       : clock (shared with the SRAM), synchronous active-high reset
//   WR_PTR          : producer write pointer, ADDR_W+1 bits, MSB is the wrap bit
//   FLUSH           : discard every unread byte; RD_PTR jumps to WR_PTR
//   RADDR, REN, RD  : SRAM read port; RD is valid the cycle after REN
//   RD_PTR          : read-issue pointer handed back to the producer for full detection
//   EMPTY           : nothing left in SRAM, in flight, or buffered
//   TDATA/TVALID/TREADY : output byte stream
//   LEVEL           : only with ISP_BUF_READER_LEVEL_EN defined; total bytes still owed
//                     to the stream (SRAM backlog + in flight + buffered), 0..2**ADDR_W+2
module isp_buf_reader
  import isp_buf_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              CLK,
  input  logic              SRST,
  input  logic [ADDR_W:0]   WR_PTR,
  input  logic              FLUSH,
  output logic [ADDR_W-1:0] RADDR,
  output logic              REN,
  input  logic [DATA_W-1:0] RD,
  output logic [ADDR_W:0]   RD_PTR,
  output logic              EMPTY,
  output logic [DATA_W-1:0] TDATA,
  output logic              TVALID,
  input  logic              TREADY
`ifdef ISP_BUF_READER_LEVEL_EN
  ,
  output logic [ADDR_W+1:0] LEVEL
`endif
);

  localparam int PW    = ADDR_W + 1;
  localparam int OCC_W = CNT_W + 1;

  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic             inflight_q, inflight_d;

  logic [CNT_W-1:0] obuf_cnt;
  logic [OCC_W-1:0] occ;
  logic             avail;
  logic             pop;
  logic             ren;

  // Output FIFO: the byte read in the previous cycle is captured
  // unconditionally; the issue rule guarantees there is room for it.
  isp_buf_reader_obuf #(
    .DATA_W (DATA_W)
  ) u_obuf (
    .clk      (CLK),
    .srst     (SRST),
    .flush    (FLUSH),
    .push     (inflight_q),
    .push_dat (RD),
    .pop      (pop),
    .cnt      (obuf_cnt),
    .head_dat (TDATA)
  );

  assign TVALID = (obuf_cnt != '0);
  assign pop    = TVALID & TREADY;
  assign avail  = (WR_PTR != rd_ptr_q);

  // Bytes already committed to the FIFO: held entries plus the read that
  // lands next cycle. A new read is allowed while that stays within the
  // FIFO depth, counting a pop in this cycle as freeing one slot.
  assign occ = OCC_W'(obuf_cnt) + OCC_W'(inflight_q);

  always_comb begin
    ren        = 1'b0;
    rd_ptr_d   = rd_ptr_q;
    inflight_d = 1'b0;

    if (avail && !FLUSH && !SRST) begin
      if ((occ < OCC_W'(OBUF_DEPTH)) || ((occ == OCC_W'(OBUF_DEPTH)) && pop)) begin
        ren = 1'b1;
      end
    end

    if (FLUSH) begin
      // Everything the producer has published so far is considered consumed;
      // the read in flight (if any) is dropped by the FIFO flush.
      rd_ptr_d = WR_PTR;
    end else if (ren) begin
      rd_ptr_d   = rd_ptr_q + PW'(1);
      inflight_d = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (SRST) begin
      rd_ptr_q   <= '0;
      inflight_q <= 1'b0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      inflight_q <= inflight_d;
    end
  end

  assign REN    = ren;
  assign RADDR  = rd_ptr_q[ADDR_W-1:0];
  assign RD_PTR = rd_ptr_q;
  assign EMPTY  = ~avail & ~inflight_q & (obuf_cnt == '0);

`ifdef ISP_BUF_READER_LEVEL_EN
  // Moving a byte from SRAM to in-flight to the FIFO leaves the sum
  // unchanged; only a pop or a producer write changes it.
  logic [ADDR_W+1:0] lvl_backlog;

  assign lvl_backlog = (ADDR_W+2)'(ptr_diff(PTR_W_MAX'(WR_PTR), PTR_W_MAX'(rd_ptr_q), PW));
  assign LEVEL       = lvl_backlog + (ADDR_W+2)'(inflight_q) + (ADDR_W+2)'(obuf_cnt);
`endif

endmodule

// File: doc/isp_buf_reader.md
Name: isp_buf_reader

Overview:
- Read-side engine for the 64x8 two-port SRAM buffer in the MSS-based ISP datapath.
- The producer writes bytes into the SRAM and publishes a write pointer. This block issues SRAM reads (REN/RADDR), absorbs the 1-cycle read latency, and presents bytes as a valid/ready stream toward the flash-programming logic.
- It returns its read pointer to the producer for full detection.

Parameters:
- ADDR_W, 6, SRAM address width. Depth = 2**ADDR_W.
- DATA_W, 8, SRAM/stream data width.

Ports:
- CLK  in  1  single clock; same CLK as the SRAM.
- SRST  in  1  synchronous reset, active-high.
- WR_PTR  in  ADDR_W+1  producer write pointer; MSB is the wrap bit; same clock domain.
- FLUSH  in  1  synchronous discard of all unread data.
- RADDR  out  ADDR_W  SRAM read address.
- REN  out  1  SRAM read enable.
- RD  in  DATA_W  SRAM read data; valid the cycle after REN.
- RD_PTR  out  ADDR_W+1  read-issue pointer returned to the producer.
- EMPTY  out  1  high when no data is in the SRAM, none in flight, and none buffered.
- TDATA  out  DATA_W  stream byte.
- TVALID  out  1  stream valid.
- TREADY  in  1  stream ready.

Behaviour:
- Reset (SRST high at an edge): RD_PTR=0, REN=0, RADDR=0, TVALID=0, TDATA=0, EMPTY=1, buffer count=0, inflight=0.
- SRST overrides FLUSH and all other inputs.
- Pointers are ADDR_W+1 bits and wrap modulo 2**(ADDR_W+1). RADDR = RD_PTR[ADDR_W-1:0].
- avail = (WR_PTR != RD_PTR).
- pop = TVALID & TREADY.
- Issue rule: REN = avail & ~FLUSH & ((cnt + inflight) < 2 | ((cnt + inflight) == 2 & pop)).
  - REN and RADDR are combinational from registered state, WR_PTR, TREADY and FLUSH.
- On an issue edge: RD_PTR += 1 and inflight is set to 1; otherwise inflight is set to 0.
  - The producer may overwrite the issued address from the next cycle onward.
- Cycle after issue: RD is written into a 2-entry output FIFO (cnt <= 2). A simultaneous pop and capture leaves cnt unchanged.
- TVALID = (cnt != 0). TDATA = head entry. TDATA holds stable while TVALID & ~TREADY.
- Latency: WR_PTR becomes != RD_PTR in cycle N → REN in N → TVALID in N+2.
- Throughput: 1 byte/cycle with TREADY held high, with no bubbles after the first byte.
- Backpressure: with TREADY low, at most 2 bytes are buffered and REN stays low. RD_PTR then lags WR_PTR, so the producer sees the SRAM fill.
- Full SRAM (WR_PTR - RD_PTR == 2**ADDR_W): treated as ordinary nonzero data. A difference above 2**ADDR_W is a producer error and is not detected.
- FLUSH at an edge:
  - RD_PTR <= WR_PTR.
  - cnt <= 0, inflight <= 0.
  - An in-flight RD is discarded.
  - TVALID is low the next cycle.
  - REN is forced low in the FLUSH cycle.
- EMPTY = ~avail & ~inflight & (cnt == 0). It is registered-state derived, with no combinational path from TREADY.

Optional Feature:
- Macro: ISP_BUF_READER_LEVEL_EN.
- Defined: adds output LEVEL [ADDR_W+1:0] = (WR_PTR - RD_PTR) + inflight + cnt. It is combinational from registers and WR_PTR; range 0..2**ADDR_W+2. Reset value 0; FLUSH forces it to 0 the following cycle.
- Undefined: no LEVEL port, and no extra logic.

Decomposition:
- Package isp_buf_pkg:
  - ADDR_W/DATA_W defaults.
  - PTR_W = ADDR_W+1.
  - FIFO depth constant OBUF_DEPTH=2.
  - Function ptr_diff() for the modulo subtraction.
- Sub-module isp_buf_reader_obuf: the 2-entry output FIFO with push, pop, flush and cnt. The top level holds the pointer, inflight and issue logic.

Test Plan:
- Reset then idle: hold SRST 3 cycles with WR_PTR=0 → REN=0, TVALID=0, EMPTY=1, RD_PTR=0, TDATA=0.
- Single byte: SRAM[0]=0xA5, WR_PTR 0→1 at cycle N → REN=1 with RADDR=0 in N; TVALID=1, TDATA=0xA5 in N+2; RD_PTR=1; EMPTY=1 after the pop.
- Burst with wrap: preload 64 bytes (value=addr), RD_PTR starting at 60, WR_PTR=60+64 mod 128, TREADY=1 → 64 bytes in order 60..63,0..59 on consecutive cycles, with RADDR wrapping 63→0 and RD_PTR ending at 124.
- Backpressure: WR_PTR-RD_PTR=10, TREADY=0 → exactly 2 reads issued, cnt=2, TDATA stable. Then release TREADY → the remaining 8 bytes are gapless and in order.
- FLUSH mid-stream: 5 bytes pending with a read in flight, pulse FLUSH → TVALID=0 next cycle, RD_PTR==WR_PTR, EMPTY=1, and no stale byte appears afterward.
- LEVEL (with ISP_BUF_READER_LEVEL_EN): WR_PTR-RD_PTR=64, TREADY=0, run until stable → LEVEL=64 throughout (transfers from SRAM to buffer preserve the total). Then pop 1 → LEVEL=63.
